// File: rtl/seq_cla_multiplier.sv
// rtl/seq_cla_multiplier.sv - iterative shift-and-add multiplier built on an N-bit carry-lookahead adder
// Optional signed mode: define SEQ_CLA_MULT_SIGNED_EN.
module seq_cla_multiplier #(
  parameter int N = 32,
  parameter int M = 32,
  localparam int CNT_W = $clog2(M + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     multicand,
  input  logic [M-1:0]     multiplier,
`ifdef SEQ_CLA_MULT_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   product,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(M - 1);

  state_t             state_q, state_d;
  logic [N-1:0]       mcand_q, mcand_d;
  logic [N+M-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [N+M-1:0]     product_q, product_d;
  logic               neg_q, neg_d;

  logic [N-1:0]       cla_a, cla_b, cla_g, cla_p, cla_sum;
  logic [N:0]         cla_c;
  logic [N+M-1:0]     acc_shift;
  logic [N-1:0]       mc_mag;
  logic [M-1:0]       mp_mag;
  logic               neg_in;

  // Upper half of the accumulator plus the multiplicand when the current multiplier bit is set.
  assign cla_a    = acc_q[N+M-1:M];
  assign cla_b    = acc_q[0] ? mcand_q : '0;
  assign cla_c[0] = 1'b0;

  for (genvar j = 0; j < N; j++) begin : g_cla
    assign cla_g[j]   = cla_a[j] & cla_b[j];
    assign cla_p[j]   = cla_a[j] | cla_b[j];
    assign cla_c[j+1] = cla_g[j] | (cla_p[j] & cla_c[j]);
    assign cla_sum[j] = cla_a[j] ^ cla_b[j] ^ cla_c[j];
  end

  assign acc_shift = {cla_c[N], cla_sum, acc_q[M-1:1]};

`ifdef SEQ_CLA_MULT_SIGNED_EN
  // Magnitudes of most-negative values wrap to 2^(W-1), which is correct read as unsigned.
  assign mc_mag = (is_signed && multicand[N-1])  ? (~multicand + N'(1))  : multicand;
  assign mp_mag = (is_signed && multiplier[M-1]) ? (~multiplier + M'(1)) : multiplier;
  assign neg_in = is_signed & (multicand[N-1] ^ multiplier[M-1]);
`else
  assign mc_mag = multicand;
  assign mp_mag = multiplier;
  assign neg_in = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    neg_d     = neg_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = mc_mag;
          acc_d   = {{N{1'b0}}, mp_mag};
          count_d = '0;
          neg_d   = neg_in;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_shift;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
`ifdef SEQ_CLA_MULT_SIGNED_EN
          product_d = neg_q ? (~acc_shift + (N+M)'(1)) : acc_shift;
`else
          product_d = acc_shift;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      neg_q     <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_cla_multiplier.sv
// tb/tb_seq_cla_multiplier.sv - directed vector bench for seq_cla_multiplier (N=M=8 and N=32,M=16)
module tb_seq_cla_multiplier;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  mc8, mp8;
  logic [15:0] product;
`ifdef SEQ_CLA_MULT_SIGNED_EN
  logic        is_signed8;
`endif

  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, busy_w;
  logic [31:0] mc_w;
  logic [15:0] mp_w;
  logic [47:0] product_w;

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_cla_multiplier #(.N(8), .M(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .multicand(mc8), .multiplier(mp8),
`ifdef SEQ_CLA_MULT_SIGNED_EN
    .is_signed(is_signed8),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  seq_cla_multiplier #(.N(32), .M(16)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_w), .in_ready(in_ready_w),
    .multicand(mc_w), .multiplier(mp_w),
`ifdef SEQ_CLA_MULT_SIGNED_EN
    .is_signed(1'b0),
`endif
    .out_valid(out_valid_w), .out_ready(out_ready_w),
    .product(product_w), .busy(busy_w)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int lat;
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    mc8 = a; mp8 = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("in_ready_low_in_calc", in_ready, 0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    check("latency", lat, 8);
    check("product", product, exp);
    @(posedge clk); #1;
    check("out_valid_cleared", out_valid, 0);
    check("in_ready_returns", in_ready, 1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'h00, 8'hFF, 16'h0000};
    vecs[2] = '{8'h01, 8'h80, 16'h0080};
    vecs[3] = '{8'hAA, 8'h55, 16'h3872};
    vecs[4] = '{8'h0F, 8'h10, 16'h00F0};
    vecs[5] = '{8'h80, 8'h02, 16'h0100};
    vecs[6] = '{8'h12, 8'h34, 16'h03A8};

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; mc8 = 8'h5A; mp8 = 8'h3C;
    in_valid_w = 1'b0; out_ready_w = 1'b1; mc_w = '0; mp_w = '0;
`ifdef SEQ_CLA_MULT_SIGNED_EN
    is_signed8 = 1'b0;
`endif

    // Reset held with in_valid asserted: nothing is accepted.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", busy, 0);

    for (int i = 0; i < 7; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].p);

    // Backpressure, with in_valid pulses during CALC and DONE that must be ignored.
    @(negedge clk);
    mc8 = 8'h12; mp8 = 8'h34; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    mc8 = 8'hFF; mp8 = 8'hFF;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    check("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      @(posedge clk); #1;
      check("bp_out_valid_held", out_valid, 1);
      check("bp_product_held", product, 16'h03A8);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("product_kept_after_handshake", product, 16'h03A8);

    // Reset mid-calculation at count=4.
    @(negedge clk);
    mc8 = 8'hAA; mp8 = 8'h55; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h03, 8'h07, 16'h0015);

    // Wide instance: N=32, M=16.
    @(negedge clk);
    mc_w = 32'hFFFF_FFFF; mp_w = 16'hFFFF; in_valid_w = 1'b1;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid_w) begin lat = i; break; end
    end
    check("wide_latency", lat, 16);
    check("wide_product", product_w, 48'hFFFE_FFFF_0001);
    @(posedge clk); #1;
    check("wide_in_ready", in_ready_w, 1);

`ifdef SEQ_CLA_MULT_SIGNED_EN
    is_signed8 = 1'b1;
    do_op(8'h80, 8'h80, 16'h4000);
    do_op(8'hFF, 8'h05, 16'hFFFB);
    is_signed8 = 1'b0;
    do_op(8'hFF, 8'h05, 16'h04FB);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
